// File: rtl/router_pkg.sv
// Shared constants, types and helpers for the 5-port mesh router.
package router_pkg;

  localparam int NPORT = 5;
  localparam int DIRW  = 3;

  localparam int PORT_CORE = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_N    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_S    = 4;

  localparam int HEAD_BIT = 33;
  localparam int TAIL_BIT = 32;
  localparam int DST_MSB  = 27;
  localparam int DST_LSB  = 24;

  typedef logic [DIRW-1:0] port_idx_t;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_t;

  // Round-robin successor; wraps from the last port back to port 0.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(NPORT - 1)) ? '0 : port_idx_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/router_switch_allocator_if.sv
// Request/grant bundle between the input ports, the crossbar and the switch allocator.
interface router_switch_allocator_if;
  import router_pkg::*;

  logic [NPORT-1:0]      in_req;
  logic [NPORT-1:0]      in_head;
  logic [NPORT-1:0]      in_tail;
  logic [NPORT*DIRW-1:0] in_dir;
  logic [NPORT-1:0]      out_xfer;
  logic [NPORT-1:0]      out_lock;
  logic [NPORT*DIRW-1:0] out_sel;
  logic [NPORT-1:0]      in_gnt;
  logic                  dir_err;

  modport master (
    output in_req, in_head, in_tail, in_dir, out_xfer,
    input  out_lock, out_sel, in_gnt, dir_err
  );

  modport slave (
    input  in_req, in_head, in_tail, in_dir, out_xfer,
    output out_lock, out_sel, in_gnt, dir_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, scanning upward mod NPORT.
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  port_idx_t        ptr,
  output logic [NPORT-1:0] gnt,
  output port_idx_t        idx
);

  logic [DIRW:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NPORT; k++) begin
      pos = {1'b0, ptr} + (DIRW+1)'(k);
      if (pos >= (DIRW+1)'(NPORT)) begin
        pos = pos - (DIRW+1)'(NPORT);
      end
      if (!found && req[pos[DIRW-1:0]]) begin
        found                = 1'b1;
        gnt[pos[DIRW-1:0]]   = 1'b1;
        idx                  = pos[DIRW-1:0];
      end
    end
  end

endmodule

// File: rtl/router_switch_allocator.sv
// Per-output wormhole allocator: a head wins its output one cycle later and holds it until
// the tail handshakes there; a released output idles one cycle before re-arbitration.
module router_switch_allocator
  import router_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  router_switch_allocator_if.slave alloc
);

  out_state_t       state_q [NPORT];
  out_state_t       state_d [NPORT];
  port_idx_t        sel_q   [NPORT];
  port_idx_t        sel_d   [NPORT];
  port_idx_t        rr_q    [NPORT];
  port_idx_t        rr_d    [NPORT];
  logic             err_q;
  logic             err_d;
  logic [NPORT-1:0] cand    [NPORT];
  logic [NPORT-1:0] arb_gnt [NPORT];
  port_idx_t        arb_idx [NPORT];
  logic [NPORT-1:0] owned;
  logic [NPORT-1:0] lock_vec;
  logic [NPORT*DIRW-1:0] sel_vec;
  logic             bad_dir;

  always_comb begin
    owned = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (state_q[o] == OUT_LOCKED) owned[sel_q[o]] = 1'b1;
    end
  end

  // Owners are excluded so each input holds at most one output at a time.
  always_comb begin
    bad_dir = 1'b0;
    for (int o = 0; o < NPORT; o++) cand[o] = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (alloc.in_req[i] && alloc.in_head[i]) begin
        if (alloc.in_dir[i*DIRW +: DIRW] >= port_idx_t'(NPORT)) begin
          bad_dir = 1'b1;
        end else if (!owned[i]) begin
          cand[alloc.in_dir[i*DIRW +: DIRW]][i] = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arbiter u_arb (
      .req (cand[o]),
      .ptr (rr_q[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o])
    );
  end

  always_comb begin
    err_d = err_q | bad_dir;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      sel_d[o]   = sel_q[o];
      rr_d[o]    = rr_q[o];
      case (state_q[o])
        OUT_IDLE: begin
          if (|arb_gnt[o]) begin
            state_d[o] = OUT_LOCKED;
            sel_d[o]   = arb_idx[o];
          end
        end
        OUT_LOCKED: begin
          if (alloc.out_xfer[o] && alloc.in_tail[sel_q[o]]) begin
            state_d[o] = OUT_IDLE;
            rr_d[o]    = next_port(sel_q[o]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= OUT_IDLE;
        sel_q[o]   <= '0;
        rr_q[o]    <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        sel_q[o]   <= sel_d[o];
        rr_q[o]    <= rr_d[o];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    lock_vec = '0;
    sel_vec  = '0;
    for (int o = 0; o < NPORT; o++) begin
      lock_vec[o]             = (state_q[o] == OUT_LOCKED);
      sel_vec[o*DIRW +: DIRW] = sel_q[o];
    end
  end

  assign alloc.out_lock = lock_vec;
  assign alloc.out_sel  = sel_vec;
  assign alloc.in_gnt   = owned;
  assign alloc.dir_err  = err_q;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Bench for router_switch_allocator: directed vector table, async-reset sequence, random vs model.
module tb_router_switch_allocator;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  router_switch_allocator_if bus();

  router_switch_allocator dut (
    .clk   (clk),
    .rst   (rst),
    .alloc (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  req;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [14:0] dir;
    logic [4:0]  xfer;
    logic [4:0]  lock;
    logic [4:0]  gnt;
    logic [14:0] sel;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  // Reference state: owning input per output (-1 when free), next-priority input, sticky error.
  int owner [NPORT];
  int ptr   [NPORT];
  bit err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] dv(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [14:0] masked_sel(input logic [14:0] sel, input logic [4:0] lock);
    logic [14:0] m = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (lock[o]) m[o*3 +: 3] = sel[o*3 +: 3];
    end
    return m;
  endfunction

  task automatic add(input logic [4:0] req, input logic [4:0] head, input logic [4:0] tail,
                     input logic [14:0] dir, input logic [4:0] xfer, input logic [4:0] lock,
                     input logic [4:0] gnt, input logic [14:0] sel, input logic err);
    vec_t v;
    v.req = req; v.head = head; v.tail = tail; v.dir = dir; v.xfer = xfer;
    v.lock = lock; v.gnt = gnt; v.sel = sel; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] req, input logic [4:0] head, input logic [4:0] tail,
                       input logic [14:0] dir, input logic [4:0] xfer);
    bus.in_req   = req;
    bus.in_head  = head;
    bus.in_tail  = tail;
    bus.in_dir   = dir;
    bus.out_xfer = xfer;
  endtask

  task automatic model_reset();
    for (int o = 0; o < NPORT; o++) begin
      owner[o] = -1;
      ptr[o]   = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic model_step();
    int nown [NPORT];
    int nptr [NPORT];
    bit busy [NPORT];
    int cand_in;
    int d;
    for (int i = 0; i < NPORT; i++) busy[i] = 1'b0;
    for (int o = 0; o < NPORT; o++) if (owner[o] >= 0) busy[owner[o]] = 1'b1;
    for (int o = 0; o < NPORT; o++) begin
      nown[o] = owner[o];
      nptr[o] = ptr[o];
      if (owner[o] >= 0) begin
        if (bus.out_xfer[o] && bus.in_tail[owner[o]]) begin
          nown[o] = -1;
          nptr[o] = (owner[o] + 1) % NPORT;
        end
      end else begin
        for (int k = 0; k < NPORT; k++) begin
          cand_in = (ptr[o] + k) % NPORT;
          d = int'(bus.in_dir[3*cand_in +: 3]);
          if (nown[o] < 0 && bus.in_req[cand_in] && bus.in_head[cand_in] && !busy[cand_in] && d == o)
            nown[o] = cand_in;
        end
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      if (bus.in_req[i] && bus.in_head[i] && int'(bus.in_dir[3*i +: 3]) >= NPORT) err_m = 1'b1;
    end
    owner = nown;
    ptr   = nptr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    logic [4:0]  el = '0;
    logic [4:0]  eg = '0;
    logic [14:0] es = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (owner[o] >= 0) begin
        el[o]         = 1'b1;
        eg[owner[o]]  = 1'b1;
        es[o*3 +: 3]  = 3'(owner[o]);
      end
    end
    chk($sformatf("rnd%0d_lock", cyc), 32'(bus.out_lock), 32'(el));
    chk($sformatf("rnd%0d_gnt", cyc), 32'(bus.in_gnt), 32'(eg));
    chk($sformatf("rnd%0d_sel", cyc), 32'(masked_sel(bus.out_sel, bus.out_lock)), 32'(es));
    chk($sformatf("rnd%0d_err", cyc), 32'(bus.dir_err), 32'(err_m));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] d4, d2, d1, dp, de;
    d4 = dv(4,4,4,4,4); d2 = dv(2,2,2,2,2); d1 = dv(1,1,1,1,1);
    dp = dv(3,0,0,0,0); de = dv(0,0,6,0,0);

    // Contention on output 4: winners 0, 2, 3, then pointer sits at 4 and wraps to 0.
    add(5'b01101, 5'b01101, 5'b00000, d4, 5'b00000, 5'b10000, 5'b00001, dv(0,0,0,0,0), 1'b0);
    add(5'b01101, 5'b01100, 5'b00001, d4, 5'b10000, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b01100, 5'b01100, 5'b00000, d4, 5'b00000, 5'b10000, 5'b00100, dv(0,0,0,0,2), 1'b0);
    add(5'b01100, 5'b01000, 5'b00100, d4, 5'b10000, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b01000, 5'b01000, 5'b00000, d4, 5'b00000, 5'b10000, 5'b01000, dv(0,0,0,0,3), 1'b0);
    add(5'b01000, 5'b00000, 5'b01000, d4, 5'b10000, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b10001, 5'b10001, 5'b00000, d4, 5'b00000, 5'b10000, 5'b10000, dv(0,0,0,0,4), 1'b0);
    add(5'b10001, 5'b00001, 5'b10000, d4, 5'b10000, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b00001, 5'b00001, 5'b00000, d4, 5'b00000, 5'b10000, 5'b00001, dv(0,0,0,0,0), 1'b0);
    add(5'b00001, 5'b00000, 5'b00001, d4, 5'b10000, 5'b00000, 5'b00000, 15'd0, 1'b0);
    // Non-header flit and transfers on idle outputs are ignored.
    add(5'b00010, 5'b00000, 5'b00010, dv(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
    // Wrap-around on output 2: pointer 4 picks input 4 over input 1, then wraps to 0.
    add(5'b01000, 5'b01000, 5'b00000, d2, 5'b00000, 5'b00100, 5'b01000, dv(0,0,3,0,0), 1'b0);
    add(5'b01000, 5'b00000, 5'b01000, d2, 5'b00100, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b10010, 5'b10010, 5'b00000, d2, 5'b00000, 5'b00100, 5'b10000, dv(0,0,4,0,0), 1'b0);
    add(5'b10010, 5'b00010, 5'b10000, d2, 5'b00100, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b00010, 5'b00010, 5'b00000, d2, 5'b00000, 5'b00100, 5'b00010, dv(0,0,1,0,0), 1'b0);
    add(5'b00010, 5'b00000, 5'b00010, d2, 5'b00100, 5'b00000, 5'b00000, 15'd0, 1'b0);
    // Three-flit packet holds output 1 against input 3.
    add(5'b01001, 5'b01001, 5'b00000, d1, 5'b00000, 5'b00010, 5'b00001, dv(0,0,0,0,0), 1'b0);
    add(5'b01001, 5'b01001, 5'b00000, d1, 5'b00010, 5'b00010, 5'b00001, dv(0,0,0,0,0), 1'b0);
    add(5'b01001, 5'b01000, 5'b00000, d1, 5'b00010, 5'b00010, 5'b00001, dv(0,0,0,0,0), 1'b0);
    add(5'b01001, 5'b01000, 5'b00001, d1, 5'b00010, 5'b00000, 5'b00000, 15'd0, 1'b0);
    add(5'b01000, 5'b01000, 5'b00000, d1, 5'b00000, 5'b00010, 5'b01000, dv(0,3,0,0,0), 1'b0);
    add(5'b01000, 5'b00000, 5'b01000, d1, 5'b00010, 5'b00000, 5'b00000, 15'd0, 1'b0);
    // Parallel locks; single-flit packet on output 3; owner of output 0 drops req but keeps it.
    add(5'b00011, 5'b00011, 5'b00001, dp, 5'b00000, 5'b01001, 5'b00011, dv(1,0,0,0,0), 1'b0);
    add(5'b00011, 5'b00011, 5'b00001, dp, 5'b01000, 5'b00001, 5'b00010, dv(1,0,0,0,0), 1'b0);
    add(5'b00000, 5'b00000, 5'b00000, dp, 5'b00000, 5'b00001, 5'b00010, dv(1,0,0,0,0), 1'b0);
    add(5'b00010, 5'b00000, 5'b00010, dp, 5'b00001, 5'b00000, 5'b00000, 15'd0, 1'b0);
    // Illegal direction: no lock, sticky error, later legal request still granted.
    add(5'b00100, 5'b00100, 5'b00000, de, 5'b00000, 5'b00000, 5'b00000, 15'd0, 1'b1);
    add(5'b00000, 5'b00000, 5'b00000, de, 5'b00000, 5'b00000, 5'b00000, 15'd0, 1'b1);
    add(5'b00100, 5'b00100, 5'b00000, d1, 5'b00000, 5'b00010, 5'b00100, dv(0,2,0,0,0), 1'b1);
    add(5'b00100, 5'b00000, 5'b00100, d1, 5'b00010, 5'b00000, 5'b00000, 15'd0, 1'b1);

    rst = 1'b0;
    drive(5'b0, 5'b0, 5'b0, 15'd0, 5'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lock", 32'(bus.out_lock), 32'd0);
    chk("reset_sel", 32'(bus.out_sel), 32'd0);
    chk("reset_gnt", 32'(bus.in_gnt), 32'd0);
    chk("reset_err", 32'(bus.dir_err), 32'd0);
    rst = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n].req, tbl[n].head, tbl[n].tail, tbl[n].dir, tbl[n].xfer);
      tick();
      chk($sformatf("row%0d_lock", n), 32'(bus.out_lock), 32'(tbl[n].lock));
      chk($sformatf("row%0d_gnt", n), 32'(bus.in_gnt), 32'(tbl[n].gnt));
      chk($sformatf("row%0d_sel", n), 32'(masked_sel(bus.out_sel, bus.out_lock)), 32'(tbl[n].sel));
      chk($sformatf("row%0d_err", n), 32'(bus.dir_err), 32'(tbl[n].err));
    end

    // Asynchronous reset in the middle of a packet holding output 1.
    drive(5'b00001, 5'b00001, 5'b00000, d1, 5'b00000);
    tick();
    chk("midpkt_lock", 32'(bus.out_lock), 32'b00010);
    drive(5'b00001, 5'b00000, 5'b00000, d1, 5'b00000);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_lock", 32'(bus.out_lock), 32'd0);
    chk("async_rst_gnt", 32'(bus.in_gnt), 32'd0);
    chk("async_rst_err", 32'(bus.dir_err), 32'd0);
    drive(5'b0, 5'b0, 5'b0, 15'd0, 5'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(5'b00100, 5'b00100, 5'b00000, d1, 5'b00000);
    tick();
    chk("post_rst_lock", 32'(bus.out_lock), 32'b00010);
    chk("post_rst_sel", 32'(masked_sel(bus.out_sel, bus.out_lock)), 32'(dv(0,2,0,0,0)));
    drive(5'b00100, 5'b00000, 5'b00100, d1, 5'b00010);
    tick();
    chk("post_rst_release", 32'(bus.out_lock), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      bus.in_req   = 5'($urandom);
      bus.in_head  = 5'($urandom);
      bus.in_tail  = 5'($urandom) & 5'($urandom);
      bus.out_xfer = 5'($urandom);
      for (int i = 0; i < NPORT; i++) bus.in_dir[3*i +: 3] = 3'($urandom_range(0, 5));
      tick();
      check_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
